riscv_icache_refill_fsm: RTL and testbench
==========================================

Name: riscv_icache_refill_fsm

Overview:
- Miss-handling controller for the instruction cache; it is the writer side of the icache tag array.
- Each cycle it consumes the array's hit / hit_missalign lookups and stalls the fetch stage on a miss.
- On a miss it fetches the missing block(s) from DRAM over a request/beat interface, then drives per-beat data-array writes.
- On the final beat it drives replace_tag / valid_in (primary block) or replace_tag_align / valid_in_align (next block for a misaligned instruction).

Parameters:
- IDX, 12, index width (matches tag array).
- TAG, 9, tag width (matches tag array).
- BEATS, 4, DRAM beats per cache block (power of 2, ≥2).
- BW, $clog2(BEATS), beat counter width (derived, not overridable).

Ports:
- clk  in  1  clock; posedge logic (tag array writes on the following negedge).
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch stage requests an instruction this cycle.
- missalign  in  1  current instruction straddles into the next block.
- index  in  IDX  index of the addressed block.
- tag_in  in  TAG  tag of the addressed block.
- index_missallign  in  IDX  index of the following block.
- tag_missalign  in  TAG  tag of the following block.
- hit  in  1  tag array hit for the addressed block.
- hit_missalign  in  1  tag array hit for the following block.
- stall  out  1  hold the fetch stage / PC.
- mem_req  out  1  DRAM block read request.
- mem_addr  out  TAG+IDX  block address {tag,index} of the request.
- mem_ack  in  1  DRAM accepted the request (one-cycle pulse).
- mem_rvalid  in  1  one data beat valid this cycle.
- data_we  out  1  write current beat into the data array at the primary index.
- data_we_align  out  1  write current beat into the data array at the next-block index.
- beat_sel  out  BW  word-in-block select for the data-array write.
- replace_tag  out  1  tag array update for the primary block.
- valid_in  out  1  valid value written with replace_tag.
- replace_tag_align  out  1  tag array update for the next block.
- valid_in_align  out  1  valid value written with replace_tag_align.

Behaviour:
- States: IDLE, REQ, FILL, REQ_A, FILL_A. Reset: state=IDLE, beat counter=0, latched index/tag=0.
- Reset values of all outputs: mem_req=0, data_we=0, data_we_align=0, replace_tag=0, replace_tag_align=0, valid_in=0, valid_in_align=0, beat_sel=0, stall=0.
- IDLE, lookup: need_p = fetch_req & !hit; need_a = fetch_req & missalign & !hit_missalign.
  - stall = need_p | need_a, combinational, same cycle.
  - need_p: latch {tag_in,index} and {tag_missalign,index_missallign}; go to REQ (need_p has priority over need_a).
  - Else need_a: latch both; go to REQ_A.
  - Else stay in IDLE.
- REQ / REQ_A:
  - mem_req=1, mem_addr = latched primary / latched next block address.
  - Hold both stable until mem_ack; then go to FILL / FILL_A with beat counter=0.
  - mem_rvalid arriving in REQ / REQ_A is ignored.
- FILL / FILL_A:
  - Each mem_rvalid cycle: data_we (FILL) or data_we_align (FILL_A) =1, beat_sel = counter, counter++.
  - Cycles without mem_rvalid: no write, counter holds.
  - On the beat where counter == BEATS-1:
    - FILL: replace_tag=1, valid_in=1. FILL_A: replace_tag_align=1, valid_in_align=1. Counter wraps to 0.
    - FILL next state: REQ_A if latched missalign & !hit_missalign, else IDLE.
    - FILL_A next state: IDLE.
- replace_tag and replace_tag_align are never asserted in the same cycle.
- valid_in / valid_in_align are 1 only together with their replace strobe, else 0.
- stall=1 in every state other than IDLE, including the final-beat cycle.
- On return to IDLE, the tag array (written on the intervening negedge) reports hit. Stall therefore drops one cycle after the last beat: one re-lookup cycle.
- Latched addresses drive mem_addr. Changes on index/tag inputs during a refill have no effect until IDLE.
- mem_rvalid / mem_ack in IDLE are ignored; no outputs toggle.
- Reset mid-refill: immediate return to IDLE, all strobes 0, no partial replace_tag. Tag array is cleared by the same rst. Beats from an aborted DRAM transaction are the memory side's responsibility.
- Hit in both blocks, or fetch_req=0: zero-overhead, stall=0, state stays IDLE.

Test Plan:
- Hit path: fetch_req=1, hit=1, missalign=0 -> stall=0 every cycle, mem_req never asserted.
- Primary miss: index=0x012, tag=0x1A5, hit=0, mem_ack after 3 cycles, 4 beats on consecutive cycles -> mem_addr=0x1A5012 held.
  - data_we on 4 cycles with beat_sel 0,1,2,3.
  - replace_tag=valid_in=1 only on beat 3.
  - stall drops one cycle after beat 3 (hit model returns 1).
- Misaligned double miss: index=0xFFF, index_missallign=0x000, tag_missalign=0x1A6, both misses -> primary refill then second mem_req with mem_addr=0x1A6000.
  - data_we_align beats 0..3, replace_tag_align on its last beat, never overlapping replace_tag.
- Next-block-only miss: hit=1, missalign=1, hit_missalign=0 -> direct IDLE->REQ_A, replace_tag never asserted.
- Gapped beats: mem_rvalid pattern 1,0,0,1,1,0,1 -> beat_sel 0,1,2,3 only on valid cycles; replace_tag on 7th cycle.
- Reset during FILL after 2 beats -> all outputs 0 and state IDLE same cycle; a fresh miss after reset restarts at beat_sel=0 with new mem_req.

Source files
------------

// File: rtl/riscv_icache_refill_fsm.sv
// rtl/riscv_icache_refill_fsm.sv - instruction cache miss/refill controller
// Writer side of the icache tag array: stalls fetch on a miss, refills block(s) from DRAM.
module riscv_icache_refill_fsm #(
   parameter int IDX   = 12,
   parameter int TAG   = 9,
   parameter int BEATS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_req,
   input  logic                       missalign,
   input  logic [IDX-1:0]             index,
   input  logic [TAG-1:0]             tag_in,
   input  logic [IDX-1:0]             index_missallign,
   input  logic [TAG-1:0]             tag_missalign,
   input  logic                       hit,
   input  logic                       hit_missalign,
   output logic                       stall,
   output logic                       mem_req,
   output logic [TAG+IDX-1:0]         mem_addr,
   input  logic                       mem_ack,
   input  logic                       mem_rvalid,
   output logic                       data_we,
   output logic                       data_we_align,
   output logic [$clog2(BEATS)-1:0]   beat_sel,
   output logic                       replace_tag,
   output logic                       valid_in,
   output logic                       replace_tag_align,
   output logic                       valid_in_align
);

   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, REQ, FILL, REQ_A, FILL_A} state_t;

   state_t               state, state_nx;
   logic [BW-1:0]        cnt, cnt_nx;
   logic [TAG+IDX-1:0]   p_addr, a_addr;
   logic                 pend_a;
   logic                 need_p, need_a, latch;

   assign need_p = fetch_req & ~hit;
   assign need_a = fetch_req & missalign & ~hit_missalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         p_addr <= '0;
         a_addr <= '0;
         pend_a <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (latch) begin
            p_addr <= {tag_in, index};
            a_addr <= {tag_missalign, index_missallign};
            pend_a <= need_a;
         end
      end
   end

   always_comb begin
      state_nx          = state;
      cnt_nx            = cnt;
      latch             = 1'b0;
      stall             = 1'b1;
      mem_req           = 1'b0;
      mem_addr          = '0;
      data_we           = 1'b0;
      data_we_align     = 1'b0;
      beat_sel          = '0;
      replace_tag       = 1'b0;
      valid_in          = 1'b0;
      replace_tag_align = 1'b0;
      valid_in_align    = 1'b0;
      case (state)
         IDLE: begin
            // Lookup is masked while rst is held so every output reads 0 in reset.
            stall = (need_p | need_a) & ~rst;
            latch = stall;
            if (stall) state_nx = need_p ? REQ : REQ_A;
         end
         REQ, REQ_A: begin
            mem_req  = 1'b1;
            mem_addr = (state == REQ) ? p_addr : a_addr;
            if (mem_ack) begin
               state_nx = (state == REQ) ? FILL : FILL_A;
               cnt_nx   = '0;
            end
         end
         FILL, FILL_A: begin
            beat_sel = cnt;
            if (mem_rvalid) begin
               data_we       = (state == FILL);
               data_we_align = (state == FILL_A);
               cnt_nx        = cnt + BW'(1);
               if (cnt == LAST_BEAT) begin
                  if (state == FILL) begin
                     replace_tag = 1'b1;
                     valid_in    = 1'b1;
                     state_nx    = pend_a ? REQ_A : IDLE;
                  end else begin
                     replace_tag_align = 1'b1;
                     valid_in_align    = 1'b1;
                     state_nx          = IDLE;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_riscv_icache_refill_fsm.sv
// tb/tb_riscv_icache_refill_fsm.sv - self-checking bench for riscv_icache_refill_fsm
// Inputs change 1ns after posedge, outputs are sampled on negedge; a small tag-array model drives hit.
module tb_riscv_icache_refill_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_req = 1'b0, missalign = 1'b0;
   logic [11:0] index = '0, index_missallign = '0;
   logic [8:0]  tag_in = '0, tag_missalign = '0;
   logic        hit_base = 1'b1, hm_base = 1'b1;
   logic        p_fill, a_fill;
   logic        hit, hit_missalign;
   logic        stall, mem_req, mem_ack = 1'b0, mem_rvalid = 1'b0;
   logic [20:0] mem_addr;
   logic        data_we, data_we_align, replace_tag, valid_in, replace_tag_align, valid_in_align;
   logic [1:0]  beat_sel;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic       we;
      logic       we_a;
      logic [1:0] sel;
      logic       rt;
      logic       rta;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   // Tag-array model: cleared by rst, a block reads as hit once its replace strobe has been seen.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         p_fill <= 1'b0;
         a_fill <= 1'b0;
      end else begin
         if (replace_tag) p_fill <= 1'b1;
         if (replace_tag_align) a_fill <= 1'b1;
      end
   end
   assign hit           = hit_base | p_fill;
   assign hit_missalign = hm_base | a_fill;

   riscv_icache_refill_fsm dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .missalign(missalign),
      .index(index), .tag_in(tag_in), .index_missallign(index_missallign),
      .tag_missalign(tag_missalign), .hit(hit), .hit_missalign(hit_missalign),
      .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rvalid(mem_rvalid), .data_we(data_we), .data_we_align(data_we_align),
      .beat_sel(beat_sel), .replace_tag(replace_tag), .valid_in(valid_in),
      .replace_tag_align(replace_tag_align), .valid_in_align(valid_in_align)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   task automatic do_reset();
      rst = 1'b1; fetch_req = 1'b0; missalign = 1'b0; hit_base = 1'b1; hm_base = 1'b1;
      mem_ack = 1'b0; mem_rvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Serves one DRAM transaction: waits for mem_req, acks on REQ cycle ack_delay, then plays pat[n-1:0] as rvalid.
   task automatic run_refill(input logic [20:0] addr, input bit align, input int ack_delay,
                             input logic [15:0] pat, input int n);
      exp_t e;
      int   beat = 0;
      int   w = 0;
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL miss_stall: stall=%b want 1", stall); else pass_cnt++;
      while (mem_req !== 1'b1 && w < 8) begin
         @(posedge clk); #1; @(negedge clk); w++;
      end
      total_cnt++;
      if (mem_req !== 1'b1) $display("FAIL req_timeout: mem_req never asserted"); else pass_cnt++;
      for (int i = 1; i <= ack_delay; i++) begin
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== addr || stall !== 1'b1)
            $display("FAIL req_hold: mem_req=%b mem_addr=%h stall=%b want 1/%h/1", mem_req, mem_addr, stall, addr);
         else pass_cnt++;
         mem_ack    = (i == ack_delay);
         mem_rvalid = (i == 1);
         @(posedge clk); #1;
         if (i < ack_delay) @(negedge clk);
      end
      mem_ack = 1'b0;
      for (int k = 0; k < n; k++) begin
         mem_rvalid = pat[k];
         e = '0;
         if (pat[k]) begin
            e.we   = !align;
            e.we_a = align;
            e.sel  = beat[1:0];
            e.rt   = !align && beat == 3;
            e.rta  = align && beat == 3;
            beat++;
         end
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         total_cnt++;
         if (data_we !== e.we || data_we_align !== e.we_a || replace_tag !== e.rt || valid_in !== e.rt ||
             replace_tag_align !== e.rta || valid_in_align !== e.rta || stall !== 1'b1 ||
             ((e.we | e.we_a) && beat_sel !== e.sel))
            $display("FAIL fill_cycle%0d: we=%b wea=%b sel=%0d rt=%b vi=%b rta=%b via=%b stall=%b want we=%b wea=%b sel=%0d rt=%b rta=%b stall=1",
                     k, data_we, data_we_align, beat_sel, replace_tag, valid_in, replace_tag_align,
                     valid_in_align, stall, e.we, e.we_a, e.sel, e.rt, e.rta);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; fetch_req = 1'b1; hit_base = 1'b0; mem_rvalid = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({stall, mem_req, data_we, data_we_align, beat_sel, replace_tag, valid_in, replace_tag_align, valid_in_align} !== 10'b0)
         $display("FAIL reset_outputs: stall=%b mem_req=%b we=%b wea=%b sel=%0d rt=%b vi=%b rta=%b via=%b want all 0",
                  stall, mem_req, data_we, data_we_align, beat_sel, replace_tag, valid_in, replace_tag_align, valid_in_align);
      else pass_cnt++;
      @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_hit_path();
      do_reset();
      fetch_req = 1'b1; hit_base = 1'b1; missalign = 1'b0;
      for (int i = 0; i < 4; i++) begin
         index = 12'(i * 37); tag_in = 9'(i * 11);
         @(negedge clk);
         total_cnt++;
         if (stall !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL hit_path%0d: stall=%b mem_req=%b want 0/0", i, stall, mem_req);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      fetch_req = 1'b0; hit_base = 1'b0; hm_base = 1'b0; missalign = 1'b1;
      mem_ack = 1'b1; mem_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({stall, mem_req, data_we, data_we_align, replace_tag, replace_tag_align} !== 6'b0)
            $display("FAIL idle_ignore%0d: stall=%b mem_req=%b we=%b wea=%b rt=%b rta=%b want all 0",
                     i, stall, mem_req, data_we, data_we_align, replace_tag, replace_tag_align);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; mem_rvalid = 1'b0; hit_base = 1'b1; hm_base = 1'b1; missalign = 1'b0;
   endtask

   task automatic test_primary_miss();
      do_reset();
      fetch_req = 1'b1; missalign = 1'b0; hit_base = 1'b0; index = 12'h012; tag_in = 9'h1A5;
      run_refill(21'h1A5012, 1'b0, 3, 16'b1111, 4);
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL primary_relookup: stall=%b mem_req=%b want 0/0", stall, mem_req);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_double_miss();
      do_reset();
      fetch_req = 1'b1; missalign = 1'b1; hit_base = 1'b0; hm_base = 1'b0;
      index = 12'hFFF; tag_in = 9'h1A5; index_missallign = 12'h000; tag_missalign = 9'h1A6;
      run_refill(21'h1A5FFF, 1'b0, 2, 16'b1111, 4);
      index = 12'h333; tag_missalign = 9'h011;
      run_refill(21'h1A6000, 1'b1, 1, 16'b1111, 4);
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL double_relookup: stall=%b mem_req=%b want 0/0", stall, mem_req);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_next_only();
      do_reset();
      fetch_req = 1'b1; missalign = 1'b1; hit_base = 1'b1; hm_base = 1'b0;
      index = 12'h100; tag_in = 9'h0F0; index_missallign = 12'h101; tag_missalign = 9'h0F0;
      run_refill(21'h0F0101, 1'b1, 2, 16'b1111, 4);
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL next_only_relookup: stall=%b want 0", stall); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_gapped_beats();
      do_reset();
      fetch_req = 1'b1; missalign = 1'b0; hit_base = 1'b0; index = 12'h234; tag_in = 9'h077;
      run_refill(21'h077234, 1'b0, 1, 16'b1011001, 7);
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL gapped_relookup: stall=%b want 0", stall); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      fetch_req = 1'b1; missalign = 1'b0; hit_base = 1'b0; index = 12'h055; tag_in = 9'h0AA;
      @(posedge clk); #1;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rvalid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total_cnt++;
      if (data_we !== 1'b1 || beat_sel !== 2'd1)
         $display("FAIL mid_fill_beat1: we=%b sel=%0d want 1/1", data_we, beat_sel);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({stall, mem_req, data_we, data_we_align, beat_sel, replace_tag, valid_in, replace_tag_align, valid_in_align} !== 10'b0)
         $display("FAIL mid_fill_reset: stall=%b mem_req=%b we=%b sel=%0d rt=%b want all 0",
                  stall, mem_req, data_we, beat_sel, replace_tag);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0; mem_rvalid = 1'b0;
      run_refill(21'h0AA055, 1'b0, 2, 16'b1111, 4);
   endtask

   initial begin
      test_reset();
      test_hit_path();
      test_primary_miss();
      test_double_miss();
      test_next_only();
      test_gapped_beats();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
